// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes, bus widths and the write-channel FSM state type.
package axi_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT_W, WAIT_A, RESP} wr_state_t;
endpackage

// File: rtl/axi4_write_slave_if.sv
// AXI4 write channels (AW, W, B) bundled for the write slave and its master.
interface axi4_write_slave_if;
  import axi_pkg::*;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_STRB_W-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (output awaddr, awvalid, wdata, wstrb, wvalid, bready,
                  input  awready, wready, bresp, bvalid);
  modport slave  (input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
                  output awready, wready, bresp, bvalid);
endinterface

// File: rtl/axi_wr_mem.sv
// DEPTH x 32 byte-enable RAM; one write port, one registered read port.
module axi_wr_mem
  import axi_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [AXI_DATA_W-1:0] wdata,
  input  logic [AXI_STRB_W-1:0] wstrb,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [AXI_DATA_W-1:0] rd_data
);
  logic [AXI_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < AXI_STRB_W; i++)
        if (wstrb[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
  end

  // Same-edge read of a word being written returns the pre-write value.
  always_ff @(posedge clk) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_idx];
  end
endmodule

// File: rtl/axi4_write_slave.sv
// Single-beat AXI4 write slave committing into a local byte-strobed RAM.
// Define AXI_WR_SLAVE_DECERR_EN to answer out-of-window addresses with DECERR.
module axi4_write_slave
  import axi_pkg::*;
#(
  parameter  int           DEPTH     = 64,
  parameter  logic [31:0]  BASE_ADDR = 32'h0000_0000,
  localparam int           IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  axi4_write_slave_if.slave     bus,
  input  logic [IDX_W-1:0]      rd_addr,
  output logic [AXI_DATA_W-1:0] rd_data,
  output logic [31:0]           wr_count
);
  wr_state_t             state, state_n;
  logic                  aw_held, w_held, aw_held_n, w_held_n;
  logic [AXI_ADDR_W-1:0] aw_addr_q, c_addr, off;
  logic [AXI_DATA_W-1:0] w_data_q, c_data;
  logic [AXI_STRB_W-1:0] w_strb_q, c_strb;
  logic [IDX_W-1:0]      c_idx;
  logic                  aw_hs, w_hs, commit, b_done, addr_ok, mem_we;
  logic                  unused_bits;

  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid && bus.wready;
  assign b_done = (state == RESP) && bus.bready;
  assign commit = (state == IDLE   && aw_hs && w_hs) ||
                  (state == WAIT_W && w_hs) ||
                  (state == WAIT_A && aw_hs);

  // Whichever channel arrived first is taken from its hold register.
  assign c_addr = aw_held ? aw_addr_q : bus.awaddr;
  assign c_data = w_held  ? w_data_q  : bus.wdata;
  assign c_strb = w_held  ? w_strb_q  : bus.wstrb;
  assign off    = c_addr - BASE_ADDR;
  assign c_idx  = off[IDX_W+1:2];

`ifdef AXI_WR_SLAVE_DECERR_EN
  assign addr_ok     = ({2'b00, off[31:2]} < 32'(DEPTH));
  assign unused_bits = ^off[1:0];
`else
  assign addr_ok     = 1'b1;
  assign unused_bits = ^{off[31:IDX_W+2], off[1:0]};
`endif

  assign mem_we = commit && addr_ok && reset;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (commit) state_n = RESP;
               else if (aw_hs) state_n = WAIT_W;
               else if (w_hs)  state_n = WAIT_A;
      WAIT_W:  if (w_hs)  state_n = RESP;
      WAIT_A:  if (aw_hs) state_n = RESP;
      RESP:    if (bus.bready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    aw_held_n = b_done ? 1'b0 : (aw_held || aw_hs);
    w_held_n  = b_done ? 1'b0 : (w_held  || w_hs);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= AXI_RESP_OKAY;
      wr_count    <= '0;
    end else begin
      state       <= state_n;
      aw_held     <= aw_held_n;
      w_held      <= w_held_n;
      bus.awready <= !aw_held_n && (state_n != RESP);
      bus.wready  <= !w_held_n  && (state_n != RESP);
      if (commit) begin
        bus.bvalid <= 1'b1;
        bus.bresp  <= addr_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
      end else if (b_done) begin
        bus.bvalid <= 1'b0;
      end
      if (commit && addr_ok) wr_count <= wr_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= bus.awaddr;
    if (w_hs) begin
      w_data_q <= bus.wdata;
      w_strb_q <= bus.wstrb;
    end
  end

  axi_wr_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (mem_we),
    .wr_idx  (c_idx),
    .wdata   (c_data),
    .wstrb   (c_strb),
    .rd_idx  (rd_addr),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_axi4_write_slave.sv
// Scoreboard bench for axi4_write_slave: directed cases then randomized single-beat writes.
module tb_axi4_write_slave;
  import axi_pkg::*;
  localparam int          DEPTH = 16;
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [IDX_W-1:0] rd_addr = '0;
  logic [31:0]      rd_data, wr_count;

  axi4_write_slave_if bus ();

  axi4_write_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int          nvec = 0, nerr = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] cnt_m = '0;
  logic [1:0]  exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nvec++; nerr++;
    $display("FAIL %s: no handshake within 50 cycles", name);
  endtask

  // Monitor: pops the expected response on every B handshake and checks B-channel rules.
  logic       stall_prev = 1'b0, hs_prev = 1'b0;
  logic [1:0] bresp_prev = '0, e_b;
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev <= 1'b0;
      hs_prev    <= 1'b0;
    end else begin
      if (stall_prev) begin
        chk("b_hold_valid", 32'(bus.bvalid), 32'd1);
        chk("b_hold_resp", 32'(bus.bresp), 32'(bresp_prev));
      end
      if (hs_prev) chk("b_gap", 32'(bus.bvalid), 32'd0);
      if (bus.bvalid && bus.bready) begin
        if (exp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL b_unexpected: got bresp %b expected no response", bus.bresp);
        end else begin
          e_b = exp_q.pop_front();
          chk("bresp", 32'(bus.bresp), 32'(e_b));
        end
      end
      stall_prev <= bus.bvalid && !bus.bready;
      hs_prev    <= bus.bvalid && bus.bready;
      bresp_prev <= bus.bresp;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference model: applies the write rules at the moment the transaction is issued.
  task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] off;
    int idx;
    off = a - BASE;
    idx = int'((off >> 2) % DEPTH);
`ifdef AXI_WR_SLAVE_DECERR_EN
    if (off >= 32'(DEPTH * 4)) begin
      exp_q.push_back(2'b11);
      return;
    end
`endif
    for (int i = 0; i < 4; i++)
      if (s[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
    cnt_m = cnt_m + 32'd1;
    exp_q.push_back(2'b00);
  endtask

  task automatic drive_aw(input logic [31:0] a, input int dly);
    int g;
    repeat (dly) tick();
    bus.awaddr = a; bus.awvalid = 1'b1; g = 0;
    @(negedge clk);
    while (!bus.awready && g < 50) begin g++; @(negedge clk); end
    if (!bus.awready) timeout("aw_handshake");
    tick();
    bus.awvalid = 1'b0; bus.awaddr = $urandom;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int g;
    repeat (dly) tick();
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1; g = 0;
    @(negedge clk);
    while (!bus.wready && g < 50) begin g++; @(negedge clk); end
    if (!bus.wready) timeout("w_handshake");
    tick();
    bus.wvalid = 1'b0; bus.wdata = $urandom;
  endtask

  task automatic wait_b(input int dly);
    int g;
    repeat (dly) tick();
    bus.bready = 1'b1; g = 0;
    @(negedge clk);
    while (!bus.bvalid && g < 50) begin g++; @(negedge clk); end
    if (!bus.bvalid) timeout("b_handshake");
    tick();
    bus.bready = 1'b0;
    chk("wr_count", wr_count, cnt_m);
  endtask

  task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int da, input int dw, input int db);
    model_push(a, d, s);
    fork
      drive_aw(a, da);
      drive_w(d, s, dw);
    join
    wait_b(db);
  endtask

  task automatic read_expect(input string name, input int idx, input logic [31:0] exp);
    rd_addr = IDX_W'(idx);
    tick();
    @(negedge clk);
    chk(name, rd_data, exp);
    tick();
  endtask

  task automatic check_word(input int idx);
    read_expect("rd_word", idx, mem_m[idx]);
  endtask

  initial begin
    logic [31:0] a, old5;
    int r;
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_bresp", 32'(bus.bresp), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_wr_count", wr_count, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_awready", 32'(bus.awready), 32'd1);
    chk("post_rst_wready", 32'(bus.wready), 32'd1);
    tick();

    // AW and W on the same edge
    model_push(BASE + 32'd8, 32'hDEADBEEF, 4'hF);
    fork
      drive_aw(BASE + 32'd8, 0);
      drive_w(32'hDEADBEEF, 4'hF, 0);
    join
    @(negedge clk);
    chk("t1_bvalid_next", 32'(bus.bvalid), 32'd1);
    tick();
    wait_b(0);
    chk("t1_count", wr_count, 32'd1);
    read_expect("t1_word2", 2, 32'hDEADBEEF);

    // AW first, W later
    model_push(BASE + 32'd4, 32'h11223344, 4'hF);
    drive_aw(BASE + 32'd4, 0);
    @(negedge clk);
    chk("t2_awready_wait", 32'(bus.awready), 32'd0);
    chk("t2_wready_wait", 32'(bus.wready), 32'd1);
    chk("t2_no_bvalid", 32'(bus.bvalid), 32'd0);
    tick();
    drive_w(32'h11223344, 4'hF, 2);
    wait_b(1);
    read_expect("t2_word1", 1, 32'h11223344);

    // W first, then AW; partial strobes merge into word 1
    model_push(BASE + 32'd4, 32'hAABBCCDD, 4'b0101);
    drive_w(32'hAABBCCDD, 4'b0101, 0);
    @(negedge clk);
    chk("t3_wready_wait", 32'(bus.wready), 32'd0);
    chk("t3_awready_wait", 32'(bus.awready), 32'd1);
    tick();
    drive_aw(BASE + 32'd4, 1);
    wait_b(0);
    read_expect("t3_merge", 1, 32'h11BB33DD);

    // Backpressure on B
    a = $urandom;
    model_push(BASE + 32'd12, a, 4'hF);
    fork
      drive_aw(BASE + 32'd12, 0);
      drive_w(a, 4'hF, 0);
    join
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_bvalid_held", 32'(bus.bvalid), 32'd1);
      chk("t4_ready_low", 32'({bus.awready, bus.wready}), 32'd0);
    end
    tick();
    wait_b(0);
    @(negedge clk);
    chk("t4_ready_back", 32'({bus.awready, bus.wready}), 32'd3);
    chk("t4_bvalid_low", 32'(bus.bvalid), 32'd0);
    tick();

    // bready while idle is ignored
    bus.bready = 1'b1;
    repeat (3) tick();
    chk("idle_bready_ignored", 32'(bus.bvalid), 32'd0);
    bus.bready = 1'b0;

    // Fill all words so every later read has a known value
    for (int i = 0; i < DEPTH; i++)
      xact(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);

    // One word past the window
    xact(BASE + 32'(DEPTH * 4), 32'hCAFEF00D, 4'hF, 0, 0, 1);
    check_word(0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = BASE - 32'(4 * $urandom_range(1, 4));
      else             a = BASE + 32'(4 * $urandom_range(0, DEPTH + 3)) + 32'($urandom_range(0, 3));
      xact(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      if (n % 10 == 9) check_word(int'($urandom_range(0, DEPTH - 1)));
    end
    for (int i = 0; i < DEPTH; i++) check_word(i);

    // Reset while waiting for W; W presented on the reset edge must not commit
    old5 = mem_m[5];
    drive_aw(BASE + 32'd20, 0);
    bus.wdata = 32'h0BAD0BAD; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    reset = 1'b0;
    tick();
    bus.wvalid = 1'b0;
    @(negedge clk);
    chk("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("mid_rst_ready", 32'({bus.awready, bus.wready}), 32'd0);
    chk("mid_rst_count", wr_count, 32'd0);
    cnt_m = '0;
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_release", 32'({bus.awready, bus.wready}), 32'd3);
    tick();
    read_expect("mid_rst_word5", 5, old5);
    a = $urandom;
    xact(BASE + 32'd24, a, 4'hF, 1, 0, 0);
    chk("fresh_count", wr_count, 32'd1);
    read_expect("fresh_word6", 6, a);

    repeat (2) tick();
    if (exp_q.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL b_missing: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
